instr_stream_loader: RTL and testbench
======================================

// Module: instr_stream_loader
// PURPOSE
//  Drives the CPU instruction-load interface (LoadInstructions/Instruction/Reset)
//  from the loading side. Buffers a program written word-by-word by a host. On
//  start it replays the CPU load sequence: reset pulse, one word per clock with
//  load high, then reset release. Sits between host/boot logic and the CPU top.
// PARAMETERS
//  DEPTH       16  program buffer depth in 32-bit words (power of 2)
//  AW          4   buffer address width, log2(DEPTH)
//  RST_CYCLES  1   cycles cpu_reset is held high after the last word (>=1)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  Reset      in   1   synchronous, active-high reset
//  wr_en      in   1   host write strobe; wr_data stored when accepted
//  wr_data    in   32  instruction word to buffer
//  clear      in   1   empty the buffer and return to FILL
//  start      in   1   begin streaming the buffered program
//  full       out  1   buffer holds DEPTH words
//  count      out  AW+1 number of buffered words
//  busy       out  1   high in PRE, LOAD and POST
//  done       out  1   stream complete, CPU released; held until start, clear or Reset
//  cpu_reset  out  1   to CPU Reset
//  cpu_load   out  1   to CPU LoadInstructions
//  cpu_instr  out  32  to CPU Instruction
// BEHAVIOUR
//  - Reset: state=FILL, count=0, rd_ptr=0, cpu_reset=1, cpu_load=0,
//    cpu_instr=0, busy=0, done=0, full=0. Buffer RAM is not cleared.
//    Reset mid-stream aborts immediately with the same values.
//  - FILL: cpu_reset=0. wr_en && !full stores wr_data at [count], count+1.
//    - full = (count==DEPTH). A write while full is dropped and count is unchanged.
//    - start with count==0 is ignored.
//    - start with count>0 moves to PRE.
//    - wr_en and start in the same cycle: the word is stored first, then PRE
//      (the word is included in the stream).
//  - PRE (1 cycle): cpu_reset=1, cpu_load=0, rd_ptr=0.
//  - LOAD (exactly count cycles): cpu_reset=0, cpu_load=1, cpu_instr=buf[rd_ptr],
//    rd_ptr+1 each cycle. Word k is presented in cycle k+2 after the start edge.
//    After word count-1 the state goes to POST.
//  - POST (RST_CYCLES cycles): cpu_load=0, cpu_instr=0, cpu_reset=1, using a
//    down-counter. Then DONE.
//  - DONE: cpu_reset=0, done=1, cpu_instr=0.
//    - start re-streams the same buffer (goes to PRE, done drops to 0).
//    - wr_en is ignored.
//  - clear is honoured in FILL and DONE only; it is ignored while busy.
//    - clear sets count=0, done=0 and state=FILL.
//    - clear beats start and wr_en in the same cycle; the word is dropped.
//  - wr_en, start and clear while busy are ignored. The buffer is stable during a stream.
//  - Total stream latency from the start edge to done=1 is 1+count+RST_CYCLES+1 cycles.
//  - All outputs are registered. No combinational path from inputs to cpu_* outputs.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - Adds output cpu_sum[31:0]: the modulo-2^32 sum of every word presented
//      with cpu_load=1 in the current/last stream.
//    - cpu_sum is cleared to 0 on Reset and in PRE, accumulates during LOAD,
//      and holds in POST/DONE.
//  LOADER_CHECKSUM_EN undefined:
//    - cpu_sum port and adder are absent. All other behaviour is identical.
// TESTING
//  1. Write 0x20010010,0x20020018,0x200301B4 then start -> cpu_reset=1 for 1 cycle;
//     cpu_load=1 for 3 cycles carrying those words in order; cpu_reset=1 for 1 cycle;
//     done=1 on the 6th cycle after start.
//  2. Write 17 words with DEPTH=16 -> full=1 after the 16th; the 17th is dropped;
//     count=16; the stream presents words 0..15 only.
//  3. start with count=0 -> no cpu_reset pulse; busy stays 0; state stays FILL.
//  4. Assert Reset during LOAD word 2 of 5 -> next cycle cpu_load=0, cpu_reset=1,
//     count=0, busy=0, done=0.
//  5. In DONE pulse start -> identical stream replayed. Pulse clear+start together
//     -> count=0, FILL, no stream.
//  6. (LOADER_CHECKSUM_EN) Stream 0x00000001, 0xFFFFFFFF, 0x00000010 -> cpu_sum=0x00000010
//     at done; replay resets cpu_sum to 0 in PRE.

Source files
------------

// File: rtl/instr_stream_loader.sv
// instr_stream_loader: buffers a host-written program and replays it into the CPU load interface (optional LOADER_CHECKSUM_EN adds cpu_sum)
module instr_stream_loader #(
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int RST_CYCLES = 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          clear,
  input  logic          start,
  output logic          full,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          cpu_reset,
  output logic          cpu_load,
  output logic [31:0]   cpu_instr
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   cpu_sum
`endif
);
  localparam int PW = $clog2(RST_CYCLES + 1) + 1;
  typedef enum logic [2:0] {FILL, PRE, LOAD, POST, DONE} state_t;
  state_t         state_q, state_d;
  logic [AW:0]    count_q, count_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  post_q, post_d;
  logic           cpu_reset_q, cpu_reset_d, cpu_load_q, cpu_load_d, wr_acc;
  logic [31:0]    cpu_instr_q, cpu_instr_d, word;
  logic [31:0]    mem_q [DEPTH];
  assign full      = count_q == (AW+1)'(DEPTH);
  assign count     = count_q;
  assign busy      = state_q == PRE || state_q == LOAD || state_q == POST;
  assign done      = state_q == DONE;
  assign cpu_reset = cpu_reset_q;
  assign cpu_load  = cpu_load_q;
  assign cpu_instr = cpu_instr_q;
  assign word      = mem_q[rd_ptr_q[AW-1:0]];
  // Next-state: host commands in FILL/DONE, fixed PRE/LOAD/POST sequence otherwise; cpu_* are registered from the next state
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    post_d   = post_q;
    wr_acc   = 1'b0;
    case (state_q)
      FILL: begin
        wr_acc  = wr_en && !full && !clear;
        count_d = clear ? '0 : count_q + (AW+1)'(wr_acc);
        state_d = (!clear && start && count_d != '0) ? PRE : FILL;
      end
      PRE:  state_d = LOAD;
      LOAD: begin
        state_d = (rd_ptr_q == count_q) ? POST : LOAD;
        post_d  = PW'(RST_CYCLES - 1);
      end
      POST: begin
        state_d = (post_q == '0) ? DONE : POST;
        post_d  = post_q - PW'(1);
      end
      DONE: begin
        count_d = clear ? '0 : count_q;
        state_d = clear ? FILL : start ? PRE : DONE;
      end
      default: state_d = FILL;
    endcase
    rd_ptr_d    = state_d == PRE ? '0 : state_d == LOAD ? rd_ptr_q + (AW+1)'(1) : rd_ptr_d;
    cpu_reset_d = state_d == PRE || state_d == POST;
    cpu_load_d  = state_d == LOAD;
    cpu_instr_d = cpu_load_d ? word : '0;
  end
  // State and registered CPU-side outputs
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      post_q      <= '0;
      cpu_reset_q <= 1'b1;
      cpu_load_q  <= 1'b0;
      cpu_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      post_q      <= post_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_load_q  <= cpu_load_d;
      cpu_instr_q <= cpu_instr_d;
    end
  end
  // Program buffer; not cleared by Reset
  always_ff @(posedge clk) begin
    if (wr_acc && !Reset) mem_q[count_q[AW-1:0]] <= wr_data;
  end
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  assign cpu_sum = sum_q;
  assign sum_d   = state_d == PRE ? '0 : state_d == LOAD ? sum_q + word : sum_q;
  // Running checksum of the words streamed with cpu_load high
  always_ff @(posedge clk) begin
    if (Reset) sum_q <= '0;
    else sum_q <= sum_d;
  end
`endif
endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader: self-checking bench for instr_stream_loader
module tb_instr_stream_loader;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam int R = 1;
  logic clk = 0, Reset = 1, wr_en = 0, clear = 0, start = 0;
  logic [31:0] wr_data = 0;
  logic full, busy, done, cpu_reset, cpu_load;
  logic [AW:0] count;
  logic [31:0] cpu_instr;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] cpu_sum;
`endif
  int checks = 0, errors = 0;
  logic [31:0] mbuf [DEPTH];
  int mcount = 0;
  bit mdone = 0;
  typedef struct {
    logic wr; logic [31:0] d; logic clr; logic st;
    int cnt; logic busy; logic rst;
  } vec_t;
  vec_t tbl [8];
  instr_stream_loader #(.DEPTH(DEPTH), .AW(AW), .RST_CYCLES(R)) dut (
    .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear), .start(start),
    .full(full), .count(count), .busy(busy), .done(done),
    .cpu_reset(cpu_reset), .cpu_load(cpu_load), .cpu_instr(cpu_instr)
`ifdef LOADER_CHECKSUM_EN
    , .cpu_sum(cpu_sum)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle();
    wr_en = 0; clear = 0; start = 0;
  endtask
  task automatic do_reset();
    idle();
    Reset = 1;
    tick();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_cpu_load", cpu_load, 0);
    chk("rst_cpu_instr", cpu_instr, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    Reset = 0;
    mcount = 0;
    mdone = 0;
  endtask
  task automatic host_wr(input logic [31:0] d);
    wr_en = 1; wr_data = d;
    tick();
    wr_en = 0;
    if (mcount < DEPTH) begin
      mbuf[mcount] = d;
      mcount++;
    end
  endtask
  // Called one cycle after the start edge; checks the whole stream up to done, with ignored junk on the inputs
  task automatic stream_check(input int n);
    for (int c = 1; c <= n + R + 2; c++) begin
      logic el;
      el = c >= 2 && c <= n + 1;
      chk("s_cpu_reset", cpu_reset, (c == 1 || (c > n + 1 && c <= n + 1 + R)) ? 1 : 0);
      chk("s_cpu_load", cpu_load, el);
      chk("s_cpu_instr", cpu_instr, el ? mbuf[c-2] : 32'h0);
      chk("s_busy", busy, c <= n + 1 + R ? 1 : 0);
      chk("s_done", done, c == n + R + 2 ? 1 : 0);
      chk("s_count", count, n);
      if (c <= n + R + 1) begin
        wr_en = 1'($urandom); wr_data = $urandom; clear = 1'($urandom); start = 1'($urandom);
        tick();
      end else idle();
    end
    mdone = 1;
  endtask
  initial begin
    tbl[0] = '{1, 32'hA, 0, 0, 1, 0, 0};
    tbl[1] = '{0, 32'h0, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 32'h0, 0, 1, 0, 0, 0};
    tbl[3] = '{1, 32'hB, 0, 0, 1, 0, 0};
    tbl[4] = '{1, 32'hC, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 32'hD, 0, 0, 1, 0, 0};
    tbl[6] = '{1, 32'hE, 1, 1, 0, 0, 0};
    tbl[7] = '{0, 32'h0, 0, 0, 0, 0, 0};
    do_reset();
    foreach (tbl[i]) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].d; clear = tbl[i].clr; start = tbl[i].st;
      tick();
      idle();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_cpu_reset", i), cpu_reset, tbl[i].rst);
      chk($sformatf("tbl%0d_done", i), done, 0);
    end
    do_reset();
    host_wr(32'h20010010); host_wr(32'h20020018); host_wr(32'h200301B4);
    start = 1; tick(); start = 0;
    stream_check(3);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      host_wr(32'h1000 + i);
      if (i == 14) chk("full_at15", full, 0);
      if (i == 15) chk("full_at16", full, 1);
    end
    chk("count_after17", count, 16);
    chk("full_after17", full, 1);
    start = 1; tick(); start = 0;
    stream_check(16);
    do_reset();
    for (int i = 0; i < 5; i++) host_wr($urandom);
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    chk("mid_word2", cpu_instr, mbuf[2]);
    Reset = 1; tick(); Reset = 0;
    chk("mid_cpu_load", cpu_load, 0);
    chk("mid_cpu_reset", cpu_reset, 1);
    chk("mid_count", count, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    mcount = 0; mdone = 0;
    for (int i = 0; i < 4; i++) host_wr($urandom);
    start = 1; tick(); start = 0;
    stream_check(4);
    start = 1; tick(); start = 0;
    stream_check(4);
    clear = 1; start = 1; tick(); idle();
    chk("clr_count", count, 0);
    chk("clr_done", done, 0);
    chk("clr_busy", busy, 0);
    tick();
    chk("clr_no_pre", cpu_reset, 0);
    chk("clr_still_idle", busy, 0);
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    chk("sum_reset", cpu_sum, 0);
    host_wr(32'h1); host_wr(32'hFFFFFFFF); host_wr(32'h10);
    start = 1; tick(); start = 0;
    stream_check(3);
    chk("sum_done", cpu_sum, 32'h10);
    start = 1; tick(); start = 0;
    chk("sum_pre", cpu_sum, 0);
    stream_check(3);
    chk("sum_replay", cpu_sum, 32'h10);
`endif
    do_reset();
    for (int it = 0; it < 250; it++) begin
      logic w, cl, st;
      logic [31:0] d;
      w = 1'($urandom); d = $urandom; cl = ($urandom % 8) == 0; st = ($urandom % 6) == 0;
      wr_en = w; wr_data = d; clear = cl; start = st;
      if (cl) begin
        mcount = 0; mdone = 0;
      end else if (!mdone && w && mcount < DEPTH) begin
        mbuf[mcount] = d; mcount++;
      end
      tick();
      idle();
      if (!cl && st && mcount > 0) stream_check(mcount);
      else begin
        chk("r_count", count, mcount);
        chk("r_full", full, mcount == DEPTH);
        chk("r_done", done, mdone);
        chk("r_busy", busy, 0);
        chk("r_cpu_load", cpu_load, 0);
        chk("r_cpu_reset", cpu_reset, 0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
